// File: rtl/dbg_cmd_tx_pkg.sv
// Shared constants and state encoding for the debug-governor command initiator.
package dbg_cmd_tx_pkg;

    localparam int          REG_ADDR_WIDTH  = 4;
    localparam logic [3:0]  COMMIT_REG_ADDR = 4'hF;
    localparam int          GAP_CNT_WIDTH   = 8;

    // Governor register indices decoded downstream
    localparam logic [3:0]  DROP_CNT      = 4'd0;
    localparam logic [3:0]  LOG_CNT       = 4'd1;
    localparam logic [3:0]  INJ_TDATA     = 4'd2;
    localparam logic [3:0]  INJ_TVALID    = 4'd3;
    localparam logic [3:0]  INJ_TLAST     = 4'd4;
    localparam logic [3:0]  INJ_TKEEP     = 4'd5;
    localparam logic [3:0]  INJ_TDEST     = 4'd6;
    localparam logic [3:0]  INJ_TID       = 4'd7;
    localparam logic [3:0]  KEEP_PAUSING  = 4'd8;
    localparam logic [3:0]  KEEP_LOGGING  = 4'd9;
    localparam logic [3:0]  KEEP_DROPPING = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

endpackage

// File: rtl/dbg_gap_timer.sv
// Inter-command idle timer: loadable down-counter, done when it reaches zero.
module dbg_gap_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load takes priority; otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/dbg_cmd_tx.sv
// Head-of-chain command initiator: serialises write/commit requests into
// address+data or single commit flits. All outputs are registered.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request; TVALID low
// ADDR    | address or commit flit on the bus for one cycle
// DATA    | data flit on the bus for one cycle (writes only)
// GAP     | enforced idle spacing after a command; TVALID low
module dbg_cmd_tx
    import dbg_cmd_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_SIZE   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     req_core_addr,
    input  logic [REG_ADDR_WIDTH-1:0] req_reg_addr,
    input  logic [DATA_WIDTH-1:0]     req_data,
    input  logic                      req_commit,
    input  logic                      req_TVALID,
    output logic                      req_TREADY,
    output logic [DATA_WIDTH-1:0]     cmd_out_TDATA,
    output logic                      cmd_out_TVALID,
    output logic                      busy,
    output logic                      bad_addr,
    output logic [CNT_SIZE-1:0]       cmd_cnt
);

    localparam logic [GAP_CNT_WIDTH-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? GAP_CNT_WIDTH'(GAP_CYCLES - 1) : '0;

    state_e                  state_q, state_d;
    logic                    tready_q, tready_d;
    logic                    tvalid_q, tvalid_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                    busy_q, busy_d;
    logic                    bad_q, bad_d;
    logic [CNT_SIZE-1:0]     cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    commit_q, commit_d;
    logic                    gap_load;
    logic                    gap_done;
    logic                    accept;
    logic                    is_commit;

    // TREADY is only ever high in IDLE, so it alone qualifies an accept.
    assign accept    = tready_q && req_TVALID && (state_q == ST_IDLE);
    // A write to the commit index would be decoded as a commit downstream anyway.
    assign is_commit = req_commit || (req_reg_addr == COMMIT_REG_ADDR);

    dbg_gap_timer #(
        .W(GAP_CNT_WIDTH)
    ) u_gap_timer (
        .clk       (clk),
        .rst_n     (rst),
        .load_i    (gap_load),
        .load_val_i(GAP_LOAD),
        .done_o    (gap_done)
    );

    // Next-state and next-output logic; outputs are computed for the next cycle.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        commit_d = commit_q;
        tdata_d  = '0;
        tvalid_d = 1'b0;
        bad_d    = 1'b0;
        cnt_d    = cnt_q;
        gap_load = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_ADDR;
                    data_d   = req_data;
                    commit_d = is_commit;
                    tvalid_d = 1'b1;
                    tdata_d[ADDR_WIDTH+3:4] = req_core_addr;
                    tdata_d[3:0] = is_commit ? COMMIT_REG_ADDR : req_reg_addr;
                    bad_d    = !req_commit && (req_reg_addr == COMMIT_REG_ADDR);
                    if (is_commit) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (commit_q) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_GAP;
                        gap_load = 1'b1;
                    end
                end else begin
                    state_d  = ST_DATA;
                    tdata_d  = data_q;
                    tvalid_d = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (GAP_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d  = ST_GAP;
                    gap_load = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tready_d = (state_d == ST_IDLE);
        busy_d   = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            tready_q <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            busy_q   <= 1'b0;
            bad_q    <= 1'b0;
            cnt_q    <= '0;
            data_q   <= '0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tready_q <= tready_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            busy_q   <= busy_d;
            bad_q    <= bad_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            commit_q <= commit_d;
        end
    end

    assign req_TREADY     = tready_q;
    assign cmd_out_TVALID = tvalid_q;
    assign cmd_out_TDATA  = tdata_q;
    assign busy           = busy_q;
    assign bad_addr       = bad_q;
    assign cmd_cnt        = cnt_q;

endmodule
